rf_spill_fill: RTL and testbench

- Sequencing master for the 32x32 register file: drives the RF read and write ports to spill a contiguous register range out as a word stream (save), or fill a range from an incoming word stream (restore).
- Used for context save/restore and debug dump.
- Sits between the RF ports (we/wa/wd, r1a/r1d) and a valid/ready stream fabric.
- The RF read path is combinational: rf_r1d is valid in the same cycle as rf_r1a.

---
 rtl/rf_spill_fill.sv | 118 +++++++++++
 tb/tb_rf_spill_fill.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_spill_fill.sv
// rf_spill_fill: streams a wrapping RF register range out (save) or writes it back from a stream (restore)
module rf_spill_fill #(
   parameter int NREG = 32,
   parameter int DW   = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_op,
   input  logic [4:0]    cmd_first,
   input  logic [4:0]    cmd_last,
   output logic          busy,
   output logic          done,
   output logic [4:0]    rf_r1a,
   input  logic [DW-1:0] rf_r1d,
   output logic          rf_we,
   output logic [4:0]    rf_wa,
   output logic [DW-1:0] rf_wd,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic [4:0]    out_idx,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data
);
   localparam int RW = $clog2(NREG + 1);
   typedef enum logic [1:0] {IDLE, SAVE, RESTORE, DONE} state_t;
   state_t        state_q, state_d;
   logic [4:0]    ptr_q, ptr_d;
   logic [RW-1:0] rem_q, rem_d;
   logic          out_valid_q, out_valid_d;
   logic [DW-1:0] out_data_q, out_data_d;
   logic [4:0]    out_idx_q, out_idx_d;
   logic          rf_we_q, rf_we_d;
   logic [4:0]    rf_wa_q, rf_wa_d;
   logic [DW-1:0] rf_wd_q, rf_wd_d;
   logic [RW-1:0] count;
   logic          load, in_hs;
   assign count     = RW'(5'(cmd_last - cmd_first)) + RW'(1);
   assign cmd_ready = state_q == IDLE;
   assign busy      = state_q != IDLE;
   assign done      = state_q == DONE;
   assign rf_r1a    = state_q == SAVE ? ptr_q : 5'd0;
   assign in_ready  = state_q == RESTORE && rem_q != '0;
   assign in_hs     = in_valid && in_ready;
   assign load      = state_q == SAVE && (!out_valid_q || out_ready) && rem_q != '0;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_idx   = out_idx_q;
   assign rf_we     = rf_we_q;
   assign rf_wa     = rf_wa_q;
   assign rf_wd     = rf_wd_q;
   // next state, pointer walk, output register and write-pulse generation
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      rem_d       = rem_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_idx_d   = out_idx_q;
      rf_we_d     = 1'b0;
      rf_wa_d     = rf_wa_q;
      rf_wd_d     = rf_wd_q;
      case (state_q)
         IDLE: if (cmd_valid) begin
            ptr_d   = cmd_first;
            rem_d   = count;
            state_d = cmd_op ? RESTORE : SAVE;
         end
         SAVE: if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = rf_r1d;
            out_idx_d   = ptr_q;
            ptr_d       = ptr_q + 5'd1;
            rem_d       = rem_q - RW'(1);
         end else if (out_valid_q && out_ready && rem_q == '0) begin
            out_valid_d = 1'b0;
            state_d     = DONE;
         end
         RESTORE: if (in_hs) begin
            rf_we_d = ptr_q != 5'd0;
            rf_wa_d = ptr_q;
            rf_wd_d = in_data;
            ptr_d   = ptr_q + 5'd1;
            rem_d   = rem_q - RW'(1);
         end else if (rem_q == '0) begin
            state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end
   // state and datapath registers; async reset also kills any in-flight write pulse
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         rem_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
         rf_we_q     <= 1'b0;
         rf_wa_q     <= '0;
         rf_wd_q     <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         rem_q       <= rem_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_idx_q   <= out_idx_d;
         rf_we_q     <= rf_we_d;
         rf_wa_q     <= rf_wa_d;
         rf_wd_q     <= rf_wd_d;
      end
   end
endmodule

// File: tb/tb_rf_spill_fill.sv
// tb_rf_spill_fill: directed checks of save, backpressure, restore, wrap/reg0, reset abort and busy lockout
module tb_rf_spill_fill;
   logic        clk, reset, cmd_valid, cmd_op, out_ready, in_valid;
   logic [4:0]  cmd_first, cmd_last;
   logic        cmd_ready, busy, done, rf_we, out_valid, in_ready;
   logic [4:0]  rf_r1a, rf_wa, out_idx;
   logic [31:0] rf_r1d, rf_wd, out_data, in_data;
   logic        pre_we;
   logic [4:0]  pre_a;
   logic [31:0] pre_d;
   logic [31:0] rf [32];
   logic [36:0] olog [$];
   logic [36:0] wlog [$];
   int          done_cnt, checks, failures, d0;

   rf_spill_fill dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_first(cmd_first), .cmd_last(cmd_last), .busy(busy), .done(done), .rf_r1a(rf_r1a),
      .rf_r1d(rf_r1d), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx), .in_valid(in_valid),
      .in_ready(in_ready), .in_data(in_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // register file model with r0 hardwired to zero, plus a bench preload port
   assign rf_r1d = rf_r1a == 5'd0 ? 32'd0 : rf[rf_r1a];
   always @(posedge clk) begin
      if (rf_we) rf[rf_wa] <= rf_wd;
      else if (pre_we) rf[pre_a] <= pre_d;
   end

   // logs of accepted stream words, issued writes and done cycles
   always @(posedge clk) begin
      if (out_valid && out_ready) olog.push_back({out_idx, out_data});
      if (rf_we) wlog.push_back({rf_wa, rf_wd});
      if (done) done_cnt++;
   end

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic pre(input int a, input logic [31:0] d);
      pre_we = 1'b1;
      pre_a  = 5'(a);
      pre_d  = d;
      tick();
      pre_we = 1'b0;
   endtask

   task automatic cmd(input logic op, input int f, input int l);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_first = 5'(f);
      cmd_last  = 5'(l);
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int max);
      int n;
      n = 0;
      while (!done && n < max) begin
         tick();
         n++;
      end
      chk("done_seen", {31'd0, done}, 32'd1);
   endtask

   initial begin
      checks = 0; failures = 0; done_cnt = 0;
      reset = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_first = '0; cmd_last = '0;
      out_ready = 1'b0; in_valid = 1'b0; in_data = '0;
      pre_we = 1'b0; pre_a = '0; pre_d = '0;
      tick();
      chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_r1a", {27'd0, rf_r1a}, 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_rf_wd", rf_wd, 32'd0);
      reset = 1'b1;
      tick();
      pre(3, 121); pre(4, 45); pre(5, 7); pre(9, 999); pre(10, 1010);
      // save 3..5 with the sink always ready
      olog.delete(); wlog.delete(); d0 = done_cnt;
      out_ready = 1'b1;
      cmd(1'b0, 3, 5);
      chk("s_busy", {31'd0, busy}, 32'd1);
      chk("s_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      chk("s_first_gap", {31'd0, out_valid}, 32'd0);
      chk("s_r1a", {27'd0, rf_r1a}, 32'd3);
      tick();
      chk("s_v0", {31'd0, out_valid}, 32'd1);
      chk("s_w0", {out_idx, out_data[26:0]}, {5'd3, 27'd121});
      tick();
      chk("s_w1", {out_idx, out_data[26:0]}, {5'd4, 27'd45});
      tick();
      chk("s_w2", {out_idx, out_data[26:0]}, {5'd5, 27'd7});
      tick();
      chk("s_done", {31'd0, done}, 32'd1);
      chk("s_done_ov", {31'd0, out_valid}, 32'd0);
      tick();
      chk("s_done_low", {31'd0, done}, 32'd0);
      chk("s_idle", {31'd0, cmd_ready}, 32'd1);
      chk("s_nwords", olog.size(), 32'd3);
      chk("s_no_write", wlog.size(), 32'd0);
      chk("s_done_once", done_cnt - d0, 32'd1);
      // same save with three stalled cycles on word (4,45)
      olog.delete();
      cmd(1'b0, 3, 5);
      tick();
      chk("bp_w0", {out_idx, out_data[26:0]}, {5'd3, 27'd121});
      tick();
      chk("bp_w1", {out_idx, out_data[26:0]}, {5'd4, 27'd45});
      out_ready = 1'b0;
      tick();
      chk("bp_hold1", {out_valid, out_idx, out_data[25:0]}, {1'b1, 5'd4, 26'd45});
      tick();
      chk("bp_hold2", {out_valid, out_idx, out_data[25:0]}, {1'b1, 5'd4, 26'd45});
      tick();
      chk("bp_hold3", {out_valid, out_idx, out_data[25:0]}, {1'b1, 5'd4, 26'd45});
      chk("bp_r1a_frozen", {27'd0, rf_r1a}, 32'd5);
      out_ready = 1'b1;
      tick();
      chk("bp_w2", {out_idx, out_data[26:0]}, {5'd5, 27'd7});
      tick();
      chk("bp_done", {31'd0, done}, 32'd1);
      tick();
      chk("bp_nwords", olog.size(), 32'd3);
      if (olog.size() == 3) begin
         chk("bp_log0", olog[0], {5'd3, 32'd121});
         chk("bp_log1", olog[1], {5'd4, 32'd45});
         chk("bp_log2", olog[2], {5'd5, 32'd7});
      end
      // restore 19..21 back-to-back, then save it back
      wlog.delete();
      cmd(1'b1, 19, 21);
      chk("r_in_ready", {31'd0, in_ready}, 32'd1);
      chk("r_ov_idle", {31'd0, out_valid}, 32'd0);
      in_valid = 1'b1; in_data = 100;
      tick();
      chk("r_wr0", {rf_we, rf_wa, rf_wd[25:0]}, {1'b1, 5'd19, 26'd100});
      in_data = 200;
      tick();
      chk("r_wr1", {rf_we, rf_wa, rf_wd[25:0]}, {1'b1, 5'd20, 26'd200});
      in_data = 300;
      tick();
      chk("r_wr2", {rf_we, rf_wa, rf_wd[25:0]}, {1'b1, 5'd21, 26'd300});
      chk("r_in_ready_end", {31'd0, in_ready}, 32'd0);
      in_valid = 1'b0;
      tick();
      chk("r_done", {31'd0, done}, 32'd1);
      chk("r_we_off", {31'd0, rf_we}, 32'd0);
      tick();
      chk("r_nwrites", wlog.size(), 32'd3);
      olog.delete();
      cmd(1'b0, 19, 21);
      wait_done(10);
      tick();
      chk("rs_nwords", olog.size(), 32'd3);
      if (olog.size() == 3) begin
         chk("rs_log0", olog[0], {5'd19, 32'd100});
         chk("rs_log1", olog[1], {5'd20, 32'd200});
         chk("rs_log2", olog[2], {5'd21, 32'd300});
      end
      // restore 31..1 wrapping through r0, which must not be written
      wlog.delete(); d0 = done_cnt;
      cmd(1'b1, 31, 1);
      in_valid = 1'b1; in_data = 11;
      tick();
      chk("wr_31", {rf_we, rf_wa, rf_wd[25:0]}, {1'b1, 5'd31, 26'd11});
      in_data = 22;
      tick();
      chk("wr_r0_no_we", {31'd0, rf_we}, 32'd0);
      in_data = 33;
      tick();
      chk("wr_1", {rf_we, rf_wa, rf_wd[25:0]}, {1'b1, 5'd1, 26'd33});
      chk("wr_in_ready_end", {31'd0, in_ready}, 32'd0);
      in_valid = 1'b0;
      tick();
      chk("wr_done", {31'd0, done}, 32'd1);
      tick(); tick();
      chk("wr_nwrites", wlog.size(), 32'd2);
      chk("wr_done_once", done_cnt - d0, 32'd1);
      // reset asserted right after the first handshake of restore 8..10
      wlog.delete();
      cmd(1'b1, 8, 10);
      in_valid = 1'b1; in_data = 5;
      tick();
      chk("ra_we_before", {31'd0, rf_we}, 32'd1);
      in_data = 6;
      reset = 1'b0;
      #1;
      chk("ra_we_dropped", {31'd0, rf_we}, 32'd0);
      chk("ra_busy", {31'd0, busy}, 32'd0);
      chk("ra_in_ready", {31'd0, in_ready}, 32'd0);
      tick(); tick();
      reset = 1'b1;
      in_valid = 1'b0;
      tick(); tick();
      chk("ra_busy_after", {31'd0, busy}, 32'd0);
      chk("ra_cmd_ready_after", {31'd0, cmd_ready}, 32'd1);
      chk("ra_r9", rf[9], 32'd999);
      chk("ra_r10", rf[10], 32'd1010);
      chk("ra_no_write", wlog.size(), 32'd0);
      // full 0..31 save with a command pulse during the transfer
      for (int i = 1; i < 32; i++) pre(i, 32'h1000 + 32'(i));
      olog.delete(); wlog.delete(); d0 = done_cnt;
      cmd(1'b0, 0, 31);
      for (int i = 0; i < 10; i++) tick();
      cmd_valid = 1'b1; cmd_op = 1'b1; cmd_first = 5'd5; cmd_last = 5'd5;
      chk("fr_cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
      tick();
      cmd_valid = 1'b0;
      wait_done(60);
      tick(); tick();
      chk("fr_nwords", olog.size(), 32'd32);
      for (int i = 0; i < olog.size(); i++)
         chk("fr_word", olog[i], {5'(i), i == 0 ? 32'd0 : 32'h1000 + 32'(i)});
      chk("fr_no_write", wlog.size(), 32'd0);
      chk("fr_done_once", done_cnt - d0, 32'd1);
      chk("fr_idle", {30'd0, cmd_ready, busy}, {30'd0, 2'b10});
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
